// File: rtl/sco_time_counter.sv
// sco_time_counter: 24-hour BCD HH:MM:SS counter driving six 7-segment bytes.
// Optional: define SCO_DP_BLINK_EN to blink the H0/M0 decimal points at 1 Hz.
module sco_time_counter #(
  parameter logic [25:0] CNT_1S_MAX = 26'd49_999_999,
  parameter logic        AUTO_RUN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_run,
  input  logic        key_clr,
  input  logic        ld,
  input  logic [23:0] ld_time,
  output logic        ld_err,
  output logic        tick,
  output logic        running,
  output logic [47:0] dout
);

  logic [25:0] presc;
  logic [23:0] t;
  logic [23:0] t_inc;
  logic        term;
  logic        ld_ok;
  logic        do_clr;
  logic        do_ld;
  logic        bad_ld;
  logic        dp_n;

  function automatic logic [7:0] seg7(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  assign term   = running && (presc == CNT_1S_MAX);
  assign do_clr = key_clr;
  assign do_ld  = !key_clr && ld && ld_ok;
  assign bad_ld = !key_clr && ld && !ld_ok;

  always_comb begin
    ld_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (ld_time[i*4 +: 4] > 4'd9) ld_ok = 1'b0;
    end
    if (ld_time[7:4] > 4'd5) ld_ok = 1'b0;
    if (ld_time[15:12] > 4'd5) ld_ok = 1'b0;
    if (ld_time[23:20] > 4'd2) ld_ok = 1'b0;
    if (ld_time[23:20] == 4'd2 && ld_time[19:16] > 4'd3)
      ld_ok = 1'b0;
  end

  // Ripple the carry digit by digit; hours wrap 23 -> 00.
  always_comb begin
    t_inc = t;
    if (t[3:0] != 4'd9) begin
      t_inc[3:0] = t[3:0] + 4'd1;
    end else begin
      t_inc[3:0] = 4'd0;
      if (t[7:4] != 4'd5) begin
        t_inc[7:4] = t[7:4] + 4'd1;
      end else begin
        t_inc[7:4] = 4'd0;
        if (t[11:8] != 4'd9) begin
          t_inc[11:8] = t[11:8] + 4'd1;
        end else begin
          t_inc[11:8] = 4'd0;
          if (t[15:12] != 4'd5) begin
            t_inc[15:12] = t[15:12] + 4'd1;
          end else begin
            t_inc[15:12] = 4'd0;
            if (t[23:16] == 8'h23) begin
              t_inc[23:16] = 8'h00;
            end else if (t[19:16] == 4'd9) begin
              t_inc[19:16] = 4'd0;
              t_inc[23:20] = t[23:20] + 4'd1;
            end else begin
              t_inc[19:16] = t[19:16] + 4'd1;
            end
          end
        end
      end
    end
  end

`ifdef SCO_DP_BLINK_EN
  localparam logic [26:0] HALF =
    ({1'b0, CNT_1S_MAX} + 27'd1) >> 1;
  assign dp_n = ~(running && ({1'b0, presc} < HALF));
`else
  assign dp_n = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      t       <= '0;
      running <= AUTO_RUN;
      tick    <= 1'b0;
      ld_err  <= 1'b0;
    end else begin
      tick   <= 1'b0;
      ld_err <= bad_ld;
      if (key_run) running <= ~running;
      unique case (1'b1)
        do_clr: begin
          t     <= '0;
          presc <= '0;
        end
        do_ld: begin
          t     <= ld_time;
          presc <= '0;
        end
        default: begin
          if (running) presc <= term ? '0 : presc + 26'd1;
          if (term) begin
            t    <= t_inc;
            tick <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= 48'hC0C0_C0C0_C0C0;
    end else begin
      dout <= {seg7(t[23:20]),
               seg7(t[19:16]) & {dp_n, 7'h7F},
               seg7(t[15:12]),
               seg7(t[11:8]) & {dp_n, 7'h7F},
               seg7(t[7:4]),
               seg7(t[3:0])};
    end
  end

endmodule

// File: doc/sco_time_counter.md
Name: sco_time_counter

Overview:
- Seconds-counter (SCO) model that produces the 48-bit segment bus consumed by the 6-digit multiplexed display driver.
- Keeps a 24-hour HH:MM:SS time in BCD, advanced by an internal 1 s prescaler.
- Supports run/stop, clear and BCD load.
- Encodes each digit to an active-low common-anode 7-segment byte, so the display driver only scans.

Parameters:
- CNT_1S_MAX, 26'd49_999_999: prescaler terminal count. Period is CNT_1S_MAX+1 clk cycles, i.e. 1 s at 50 MHz.
- AUTO_RUN, 1'b1: value of the running flag at reset.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous, active-low reset.
- key_run  input  1  one-cycle pulse from the debouncer; toggles run/stop.
- key_clr  input  1  one-cycle pulse; clears the time to 00:00:00.
- ld  input  1  one-cycle pulse; load ld_time.
- ld_time  input  24  BCD {H1,H0,M1,M0,S1,S0}, 4 bits each, H1 in [23:20].
- ld_err  output  1  one-cycle pulse when ld carried an illegal value.
- tick  output  1  one-cycle pulse in the cycle the BCD time registers hold the newly incremented value.
- running  output  1  current run state.
- dout  output  48  segment bytes. [47:40]=H1, [39:32]=H0, [31:24]=M1, [23:16]=M0, [15:8]=S1, [7:0]=S0.

Behaviour:
- Reset (async):
  - Prescaler 0, all BCD digits 0, running=AUTO_RUN, tick=0, ld_err=0.
  - dout=48'hC0C0C0C0C0C0 (six "0" glyphs, dp off).
- Segment byte format is {dp,g,f,e,d,c,b,a}, active-low.
  - Glyphs 0-9: C0,F9,A4,B0,99,92,82,F8,80,90.
  - Any non-BCD nibble encodes as FF (blank). This is unreachable in normal operation.
- Prescaler:
  - Increments only while running=1; holds its value while stopped.
  - Wraps CNT_1S_MAX -> 0 and raises an internal terminal pulse in that cycle.
- Time update:
  - On the clk edge after the terminal pulse, the BCD time increments by one second and tick=1 for that one cycle.
  - dout is registered from the BCD digits and updates on the following edge.
  - Total latency: prescaler terminal -> dout change = 2 cycles.
- Carry chain:
  - S0 9->0 carries into S1; S1 5->0 carries into M0; M0 9->0 carries into M1; M1 5->0 carries into the hours.
  - Hours count 00..23; 23:59:59 -> 00:00:00 with tick=1.
- Priority within one cycle: key_clr > ld > key_run > second increment.
- key_clr:
  - Digits -> 0 and prescaler -> 0; running is unchanged.
  - A simultaneous ld or terminal pulse is ignored; tick=0 in that cycle.
  - A simultaneous key_run still toggles running.
- ld:
  - Legality: every nibble <= 9, S1 <= 5, M1 <= 5, and hours <= 23 (H1 <= 2, and H0 <= 3 when H1 = 2).
  - Legal value: digits <= ld_time and prescaler -> 0. A terminal pulse in the same cycle is dropped (no tick).
  - Illegal value: digits and prescaler unchanged, ld_err=1 for one cycle. A terminal pulse in the same cycle still increments normally.
- key_run:
  - running <= ~running.
  - Stopping on the same cycle as a terminal pulse still applies that pending increment.
- Holding key_run high for N cycles toggles N times; debouncing is the upstream block's job.
- dout changes only via the registered encoder; there are no glitches between register updates.

Optional Feature:
- Macro: SCO_DP_BLINK_EN.
- When defined:
  - The dp bit (bit 7) of the H0 and M0 bytes is driven 0 (lit) while running=1 and the prescaler is below (CNT_1S_MAX+1)/2.
  - Otherwise that dp bit is 1.
  - Result: separators blink at 1 Hz while running and stay dark while stopped.
  - The dp bit is registered together with dout and has the same 1-cycle encoder delay.
- When undefined: all dp bits are constantly 1.

Test Plan:
All scenarios use CNT_1S_MAX=9.
- Reset, then run 25 cycles with AUTO_RUN=1 -> tick pulses at cycles 10 and 20 after reset release. dout[7:0]: C0 -> F9 -> A4, each change 1 cycle after its tick. Upper bytes stay C0.
- ld 24'h235958, then wait 20 cycles -> ticks give 23:59:59 then 00:00:00. After the wrap dout=48'hC0C0C0C0C0C0, no ld_err.
- ld 24'h246000 -> ld_err pulses 1 cycle. Digits and dout are unchanged, and the prescaler keeps counting (next tick arrives on schedule).
- key_run at prescaler=5 -> running=0, no tick for 50 cycles. A second key_run resumes, and the next tick arrives exactly 5 cycles later.
- key_clr and ld (legal) in the same cycle while at 12:34:56 -> digits 00:00:00, prescaler 0, no ld effect, running unchanged.
- SCO_DP_BLINK_EN defined, running -> dout[39] and dout[23] are 0 for prescaler 0-4 and 1 for 5-9 (1-cycle delayed). After stopping, both stay 1.
